// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared definitions for the ysyx_23060201 fetch path: FSM encoding and
// instruction-buffer entry layout ({pc, inst, err}).
package ysyx_23060201_ifu_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_ADDR  = 3'd1;
  localparam logic [STATE_W-1:0] S_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] S_DRAIN = 3'd3;
  localparam logic [STATE_W-1:0] S_HALT  = 3'd4;

  localparam int INST_W = 32;
  localparam int ERR_W  = 1;

  function automatic int entry_width(input int xlen);
    return xlen + INST_W + ERR_W;
  endfunction

endpackage

// File: rtl/ysyx_23060201_ifu_fifo.sv
// Instruction buffer: registered-write circular FIFO with flush, count and
// full/empty flags. Flush overrides any concurrent push or pop.
module ysyx_23060201_FIFO #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push at full is only accepted when a pop frees the head slot in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ysyx_23060201_ifu.sv
// Instruction fetch unit: one outstanding AXI-lite-style read at a time,
// responses buffered in a FIFO towards the decoder, redirect with response drain.
module ysyx_23060201_ifu
  import ysyx_23060201_ifu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h8000_0000),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_arvalid,
  output logic [XLEN-1:0]   mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              mem_rerr,
  output logic              mem_rready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_err,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);

  localparam int EW = entry_width(XLEN);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    araddr_q, araddr_d;
  logic               drain_q, drain_d;

  logic [XLEN-1:0]    redir_pc, pc_plus4;
  logic [EW-1:0]      push_entry, head_entry;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic               fifo_push, fifo_pop, fifo_flush;

  assign redir_pc   = redirect_pc & ~XLEN'(3);
  assign pc_plus4   = fetch_pc_q + XLEN'(4);
  assign push_entry = {fetch_pc_q, mem_rdata, mem_rerr};
  assign fifo_pop   = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    araddr_d   = araddr_q;
    drain_d    = drain_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          fetch_pc_d = redir_pc;
        end else if (fifo_count < CW'(FIFO_DEPTH)) begin
          state_d  = S_ADDR;
          araddr_d = fetch_pc_q;
          drain_d  = 1'b0;
        end
      end
      // The request address lives in araddr_q so a redirect here cannot disturb it.
      S_ADDR: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          fetch_pc_d = redir_pc;
          drain_d    = 1'b1;
        end
        if (mem_arready) state_d = (drain_q || redirect_valid) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          fetch_pc_d = redir_pc;
          state_d    = mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid) begin
          fifo_push  = !fifo_full;
          fetch_pc_d = pc_plus4;
          state_d    = mem_rerr ? S_HALT : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) fetch_pc_d = redir_pc;
        if (mem_rvalid)     state_d    = S_IDLE;
      end
      S_HALT: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          fetch_pc_d = redir_pc;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drain_q    <= drain_d;
    end
  end

  always_ff @(posedge clk) begin
    araddr_q <= araddr_d;
  end

  ysyx_23060201_FIFO #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign mem_arvalid = (state_q == S_ADDR);
  assign mem_araddr  = araddr_q;
  assign mem_rready  = (state_q == S_DATA) || (state_q == S_DRAIN);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);

  // Buffer storage is not reset, so the head is masked to zero whenever it is empty.
  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? '0 : head_entry[EW-1 -: XLEN];
  assign out_inst  = fifo_empty ? '0 : head_entry[INST_W:1];
  assign out_err   = fifo_empty ? 1'b0 : head_entry[0];

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Directed bench for ysyx_23060201_ifu: fetch sequencing, back-pressure,
// redirect/drain, fault halt, PC wrap and redirect-vs-pop priority.
module tb_ysyx_23060201_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rerr;
  logic        mem_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_23060201_ifu #(
    .XLEN       (32),
    .RESET_PC   (32'h8000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_arvalid    (mem_arvalid),
    .mem_araddr     (mem_araddr),
    .mem_arready    (mem_arready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_rerr       (mem_rerr),
    .mem_rready     (mem_rready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_err        (out_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic drive_idle();
    mem_arready    = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    mem_rerr       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  // Leaves the bench at the negedge where rst has just been released.
  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Memory side of one fetch: accept the request, respond dly cycles after DATA entry.
  task automatic serve_one(input int dly, input logic err,
                           output logic [31:0] addr, output logic ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_arvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      addr        = mem_araddr;
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      repeat (dly) @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = inst_of(addr);
      mem_rerr   = err;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rerr   = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    mem_rvalid = 1'b1;
    repeat (3) @(negedge clk);
    mem_rvalid = 1'b0;
    n_vec++;
    if ({mem_arvalid, mem_rready, out_valid, out_err, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_arvalid, mem_rready, out_valid, out_err, busy});
    end
    n_vec++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got pc=%h inst=%h expected 0/0", out_pc, out_inst);
    end
    rst = 1'b1;
    n_vec++;
    if (mem_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle_arvalid: got %b expected 0", mem_arvalid);
    end
    @(negedge clk);
    n_vec++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL second_cycle_req: got v=%b a=%h expected 1/80000000", mem_arvalid, mem_araddr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic        ok;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve_one(0, 1'b0, a, ok);
      n_vec++;
      if (!ok || a !== 32'h8000_0000 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL seq_addr%0d: got ok=%b a=%h expected %h", k, ok, a, 32'h8000_0000 + 32'(4 * k));
      end
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== a || out_inst !== inst_of(a) || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_out%0d: got v=%b pc=%h inst=%h err=%b expected 1/%h/%h/0",
                 k, out_valid, out_pc, out_inst, out_err, a, inst_of(a));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic        ok;
    logic        seen;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      serve_one(0, 1'b0, a, ok);
      n_vec++;
      if (!ok || a !== 32'h8000_0000 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL bp_addr%0d: got ok=%b a=%h expected %h", k, ok, a, 32'h8000_0000 + 32'(4 * k));
      end
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_arvalid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: got arvalid_seen=%b busy=%b expected 0/0", seen, busy);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL bp_head_stable: got v=%b pc=%h expected 1/80000000", out_valid, out_pc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_pc !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL bp_after_pop: got pc=%h expected 80000004", out_pc);
    end
    serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (!ok || a !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL bp_resume: got ok=%b a=%h expected 80000010", ok, a);
    end
  endtask

  task automatic test_redirect_data();
    logic [31:0] a;
    logic        ok;
    do_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL rd_req: got v=%b a=%h expected 1/80000000", mem_arvalid, mem_araddr);
    end
    mem_arready = 1'b1;
    @(negedge clk);
    mem_arready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_vec++;
    if (mem_rready !== 1'b1 || mem_arvalid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_drain: got rready=%b arvalid=%b busy=%b expected 1/0/1", mem_rready, mem_arvalid, busy);
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hdead_beef;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_discard: got out_valid=%b expected 0", out_valid);
    end
    serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (!ok || a !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL rd_new_addr: got ok=%b a=%h expected 80000100", ok, a);
    end
    n_vec++;
    if (out_pc !== 32'h8000_0100 || out_inst !== inst_of(32'h8000_0100)) begin
      n_fail++;
      $display("FAIL rd_new_out: got pc=%h inst=%h expected 80000100/%h", out_pc, out_inst, inst_of(32'h8000_0100));
    end
  endtask

  task automatic test_redirect_addr();
    logic [31:0] a;
    logic        ok;
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_vec++;
    if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL ra_hold: got v=%b a=%h expected 1/80000000", mem_arvalid, mem_araddr);
    end
    mem_arready = 1'b1;
    @(negedge clk);
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0bad_0bad;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ra_discard: got out_valid=%b expected 0", out_valid);
    end
    serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (!ok || a !== 32'h8000_0400) begin
      n_fail++;
      $display("FAIL ra_new_addr: got ok=%b a=%h expected 80000400", ok, a);
    end
  endtask

  task automatic test_fault_halt();
    logic [31:0] a;
    logic        ok;
    logic        seen;
    do_reset();
    serve_one(0, 1'b0, a, ok);
    serve_one(0, 1'b0, a, ok);
    serve_one(0, 1'b1, a, ok);
    n_vec++;
    if (!ok || a !== 32'h8000_0008) begin
      n_fail++;
      $display("FAIL fh_addr: got ok=%b a=%h expected 80000008", ok, a);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_arvalid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fh_halted: got arvalid_seen=%b busy=%b expected 0/0", seen, busy);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0008 || out_err !== 1'b1) begin
      n_fail++;
      $display("FAIL fh_entry: got v=%b pc=%h err=%b expected 1/80000008/1", out_valid, out_pc, out_err);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fh_flush: got out_valid=%b expected 0", out_valid);
    end
    serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (!ok || a !== 32'h8000_0200) begin
      n_fail++;
      $display("FAIL fh_resume: got ok=%b a=%h expected 80000200", ok, a);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    logic        ok;
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    @(negedge clk);
    redirect_valid = 1'b0;
    serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (!ok || a !== 32'hffff_fffc || out_pc !== 32'hffff_fffc) begin
      n_fail++;
      $display("FAIL wrap_top: got ok=%b a=%h pc=%h expected fffffffc", ok, a, out_pc);
    end
    serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (!ok || a !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_zero: got ok=%b a=%h expected 00000000", ok, a);
    end
  endtask

  task automatic test_redirect_pop_full();
    logic [31:0] a;
    logic        ok;
    do_reset();
    for (int k = 0; k < 4; k++) serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL rp_full_head: got v=%b pc=%h expected 1/80000000", out_valid, out_pc);
    end
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rp_flush: got out_valid=%b expected 0", out_valid);
    end
    serve_one(0, 1'b0, a, ok);
    n_vec++;
    if (!ok || a !== 32'h8000_0300 || out_pc !== 32'h8000_0300) begin
      n_fail++;
      $display("FAIL rp_refetch: got ok=%b a=%h pc=%h expected 80000300", ok, a, out_pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_data();
    test_redirect_addr();
    test_fault_halt();
    test_wrap();
    test_redirect_pop_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_ifu.md
YSYX_23060201_IFU -- requirements
Module: ysyx_23060201_IFU

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, address/PC width; RESET_PC, default 32'h8000_0000, first fetch address; FIFO_DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 mem_arvalid  output  1  fetch request valid.
REQ-005 mem_araddr  output  XLEN  fetch address, word aligned.
REQ-006 mem_arready  input  1  memory accepts request.
REQ-007 mem_rvalid  input  1  response valid.
REQ-008 mem_rdata  input  32  fetched instruction.
REQ-009 mem_rerr  input  1  response error (access fault).
REQ-010 mem_rready  output  1  IFU accepts response.
REQ-011 out_valid  output  1  buffered instruction available to IDU.
REQ-012 out_ready  input  1  IDU consumes head entry.
REQ-013 out_pc  output  XLEN  PC of head entry.
REQ-014 out_inst  output  32  instruction of head entry.
REQ-015 out_err  output  1  head entry carries fetch fault.
REQ-016 redirect_valid  input  1  branch/jump redirect strobe (from EXU).
REQ-017 redirect_pc  input  XLEN  new fetch PC; bits [1:0] SHALL be forced to 0.
REQ-018 busy  output  1  request outstanding or FSM not IDLE/HALT.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, DATA, DRAIN, HALT; at most one request outstanding.
REQ-020 IDLE->ADDR when (fifo_count + 0) < FIFO_DEPTH, i.e. a free slot exists for the response; else stay IDLE.
REQ-021 ADDR: mem_arvalid=1, mem_araddr=fetch_pc held stable until mem_arready; on arvalid&arready -> DATA.
REQ-022 DATA: mem_rready=1; on mem_rvalid write {fetch_pc, rdata, rerr} into FIFO, fetch_pc += 4 (mod 2^XLEN, wraps to 0), -> IDLE, or -> HALT if mem_rerr=1.
REQ-023 HALT: no requests issued; exit only via redirect.
REQ-024 Response->out_valid latency SHALL be 1 cycle (registered FIFO write); FIFO SHALL not be bypassed.
REQ-025 out handshake: entry popped on out_valid&out_ready; out_* stable while out_valid&!out_ready.
REQ-026 Redirect in IDLE/HALT/DATA-with-rvalid: flush FIFO, fetch_pc<=redirect_pc, next state IDLE; the concurrent response is discarded.
REQ-027 Redirect in ADDR: arvalid/araddr held until arready (no withdrawal), fetch_pc<=redirect_pc, FIFO flushed, -> DRAIN on handshake.
REQ-028 Redirect in DATA without rvalid, or in ADDR: -> DRAIN; DRAIN holds rready=1, discards one response, -> IDLE.
REQ-029 Redirect and out pop in same cycle: redirect wins; FIFO empty next cycle, out_valid=0.
REQ-030 Redirect in DRAIN: update fetch_pc only; still discard exactly one response.
REQ-031 FIFO full: no new request issued; simultaneous push/pop at full or empty SHALL keep count unchanged and data ordered.
REQ-032 mem_rvalid outside DATA/DRAIN SHALL be ignored.

Reset
REQ-033 While rst=0 at a clk edge: state=IDLE, fetch_pc=RESET_PC, FIFO empty, mem_arvalid=0, mem_rready=0, out_valid=0, out_pc=0, out_inst=0, out_err=0, busy=0.
REQ-034 First mem_arvalid SHALL assert in the second cycle after rst returns high (IDLE->ADDR); reset mid-transaction abandons it with no drain.

Structure
REQ-035 FSM state encoding and the instruction-entry field widths SHALL live in the shared defines file/package used by all ysyx_23060201 blocks.
REQ-036 Buffer SHALL be sub-module ysyx_23060201_FIFO (parametrised width/depth, push/pop/flush, count, full/empty).

Verification
REQ-037 Reset release, arready=1, rvalid 1 cycle after each request, out_ready=1 -> araddr 0x80000000, 0x80000004, 0x80000008 in order; out_pc matches each.
REQ-038 out_ready=0 with DEPTH=4 -> exactly 4 requests, then mem_arvalid stays 0; release out_ready -> fetching resumes at 0x80000010.
REQ-039 Redirect to 0x80000103 while in DATA, response arrives 2 cycles later -> response discarded, next araddr 0x80000100, FIFO empty.
REQ-040 mem_rerr=1 on PC 0x80000008 -> entry out_err=1, FSM HALT, no further arvalid; redirect to 0x80000200 -> fetch resumes there.
REQ-041 fetch_pc 0xFFFFFFFC -> next araddr 0x00000000 (wrap).
REQ-042 Redirect coinciding with out pop at full FIFO -> out_valid=0 next cycle, one subsequent fetch at redirect_pc.
